// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package data_mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_AUX  = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_OPEN       = 1'b0,
    ARB_LOCKED_AUX = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/data_mem_rd_pipe.sv
// Owner-tag shift pipeline; a tag pushed in cycle N appears on tag_o in cycle N+RD_LAT.
// No backpressure: the pipeline shifts every cycle.
module data_mem_rd_pipe
  import data_mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [RD_LAT-1:0] pipe_q;
  rd_tag_t [RD_LAT-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_i;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin core/aux arbiter for a single-port data memory; grant is same-cycle, reads return after RD_LAT.
// Requesters hold until gnt; optional aux bus lock under DATA_MEM_ARB_LOCK_EN.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic              aux_lock,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              core_elig;
  logic              lock_exit;
  logic              gnt_core, gnt_aux;
  rd_tag_t           push_tag, ret_tag;

`ifdef DATA_MEM_ARB_LOCK_EN
  lock_state_e lock_q, lock_d;

  always_comb begin
    lock_d    = lock_q;
    lock_exit = 1'b0;
    case (lock_q)
      ARB_OPEN: begin
        if (gnt_aux && aux_lock) lock_d = ARB_LOCKED_AUX;
      end
      ARB_LOCKED_AUX: begin
        if ((gnt_aux && !aux_lock) || (!aux_req && !aux_lock)) begin
          lock_d    = ARB_OPEN;
          lock_exit = 1'b1;
        end
      end
      default: lock_d = ARB_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= ARB_OPEN;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign core_elig = core_req && (lock_q == ARB_OPEN);
`else
  logic unused_aux_lock;
  assign unused_aux_lock = aux_lock;
  assign lock_exit       = 1'b0;
  assign core_elig       = core_req;
`endif

  // Grants are suppressed while reset is asserted so requesters see gnt=0.
  assign gnt_core = rst_n && core_elig && (!aux_req || last_q == OWN_AUX);
  assign gnt_aux  = rst_n && aux_req && !gnt_core;
  assign core_gnt = gnt_core;
  assign aux_gnt  = gnt_aux;

  always_comb begin
    last_d = last_q;
    addr_d = addr_q;
    data_d = data_q;
    if (gnt_core) begin
      last_d = OWN_CORE;
      addr_d = core_addr;
      data_d = core_wdata;
    end else if (gnt_aux) begin
      last_d = OWN_AUX;
      addr_d = aux_addr;
      data_d = aux_wdata;
    end
    if (lock_exit) last_d = OWN_AUX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_AUX;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      last_q <= last_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign mem_address = addr_d;
  assign mem_data    = data_d;
  assign mem_wren    = (gnt_core && core_we) || (gnt_aux && aux_we);

  always_comb begin
    push_tag       = '0;
    push_tag.vld   = (gnt_core && !core_we) || (gnt_aux && !aux_we);
    push_tag.owner = gnt_aux ? OWN_AUX : OWN_CORE;
  end

  data_mem_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .tag_i(push_tag),
    .tag_o(ret_tag)
  );

  assign core_rvalid = ret_tag.vld && (ret_tag.owner == OWN_CORE);
  assign aux_rvalid  = ret_tag.vld && (ret_tag.owner == OWN_AUX);
  assign core_rdata  = core_rvalid ? mem_q : '0;
  assign aux_rdata   = aux_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed plan steps followed by random traffic against a scoreboard model.
module tb_data_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata, aux_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_wren;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_lock(aux_lock), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    return {8'hC5, a, ~a, 8'h3A};
  endfunction

  // Synchronous memory with LAT cycles of read latency, indexed by the low address byte.
  logic          fill;
  logic [DW-1:0] envmem [256];
  logic [DW-1:0] qpipe [LAT];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) envmem[i] <= pat(i[7:0]);
    end else if (mem_wren) begin
      envmem[mem_address[7:0]] <= mem_data;
    end
    qpipe[0] <= envmem[mem_address[7:0]];
    for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
  end
  assign mem_q = qpipe[LAT-1];

  typedef struct {
    int            due;
    logic          aux;
    logic [DW-1:0] data;
  } ret_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          m_last_aux, m_locked, m_hold;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] shadow [256];
  ret_t          retq[$];
  logic          e_cg, e_ag, obs_cg, obs_ag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_core(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req = r; core_we = w; core_addr = a; core_wdata = d;
  endtask

  task automatic drive_aux(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic l);
    aux_req = r; aux_we = w; aux_addr = a; aux_wdata = d; aux_lock = l;
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge.
  task automatic step();
    logic core_elig, has;
    ret_t r;
    #1;
    core_elig = core_req && !m_locked;
    if (core_elig && aux_req) begin
      e_cg = m_last_aux;
      e_ag = !m_last_aux;
    end else begin
      e_cg = core_elig;
      e_ag = aux_req;
    end
    obs_cg = core_gnt;
    obs_ag = aux_gnt;
    chk("core_gnt", core_gnt, e_cg);
    chk("aux_gnt", aux_gnt, e_ag);
    chk("mem_wren", mem_wren, (e_cg && core_we) || (e_ag && aux_we));
    if (e_cg) begin
      chk("mem_address", mem_address, core_addr);
      chk("mem_data", mem_data, core_wdata);
    end else if (e_ag) begin
      chk("mem_address", mem_address, aux_addr);
      chk("mem_data", mem_data, aux_wdata);
    end else if (m_hold) begin
      chk("mem_address_hold", mem_address, m_addr);
      chk("mem_data_hold", mem_data, m_data);
    end
    has = (retq.size() > 0) && (retq[0].due == cyc);
    if (has) r = retq.pop_front();
    chk("core_rvalid", core_rvalid, has && !r.aux);
    chk("aux_rvalid", aux_rvalid, has && r.aux);
    chk("core_rdata", core_rdata, (has && !r.aux) ? r.data : '0);
    chk("aux_rdata", aux_rdata, (has && r.aux) ? r.data : '0);
    @(posedge clk);
    if (e_cg) begin
      if (core_we) shadow[core_addr[7:0]] = core_wdata;
      else retq.push_back('{due: cyc + LAT, aux: 1'b0, data: shadow[core_addr[7:0]]});
      m_last_aux = 1'b0;
      m_hold = 1'b1; m_addr = core_addr; m_data = core_wdata;
    end
    if (e_ag) begin
      if (aux_we) shadow[aux_addr[7:0]] = aux_wdata;
      else retq.push_back('{due: cyc + LAT, aux: 1'b1, data: shadow[aux_addr[7:0]]});
      m_last_aux = 1'b1;
      m_hold = 1'b1; m_addr = aux_addr; m_data = aux_wdata;
    end
`ifdef DATA_MEM_ARB_LOCK_EN
    if (!m_locked) begin
      if (e_ag && aux_lock) m_locked = 1'b1;
    end else if ((e_ag && !aux_lock) || (!aux_req && !aux_lock)) begin
      m_locked = 1'b0;
      m_last_aux = 1'b1;
    end
`endif
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      #1;
      chk("rst_core_gnt", core_gnt, 1'b0);
      chk("rst_aux_gnt", aux_gnt, 1'b0);
      chk("rst_mem_wren", mem_wren, 1'b0);
      chk("rst_core_rvalid", core_rvalid, 1'b0);
      chk("rst_aux_rvalid", aux_rvalid, 1'b0);
      chk("rst_core_rdata", core_rdata, '0);
      chk("rst_aux_rdata", aux_rdata, '0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    retq.delete();
    m_last_aux = 1'b1;
    m_locked = 1'b0;
    m_hold = 1'b0;
  endtask

  // Issue a fresh random request for a port unless it is still waiting for its grant.
  task automatic next_random(input logic lock_ok);
    if (!(core_req && !obs_cg))
      drive_core($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, AW'($urandom), $urandom);
    if (!(aux_req && !obs_ag))
      drive_aux($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, AW'($urandom), $urandom,
                lock_ok && ($urandom_range(0, 1) == 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] order;
    int         cw, aw;
    rst_n = 1'b0;
    fill = 1'b0;
    m_last_aux = 1'b1; m_locked = 1'b0; m_hold = 1'b0;
    m_addr = '0; m_data = '0; e_cg = 1'b0; e_ag = 1'b0; obs_cg = 1'b0; obs_ag = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i[7:0]);
    drive_core(1'b1, 1'b0, 16'h0001, 32'h0);
    drive_aux(1'b1, 1'b1, 16'h0002, 32'h1111_2222, 1'b0);
    @(negedge clk);
    fill = 1'b1;
    do_reset(3);
    fill = 1'b0;

    // Aux write alone, then the DEADBEEF word the core reads back.
    drive_core(1'b0, 1'b0, 16'h0, 32'h0);
    drive_aux(1'b1, 1'b1, 16'h0003, 32'hA5A5A5A5, 1'b0);
    step();
    drive_aux(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
    step();
    drive_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    drive_core(1'b1, 1'b0, 16'h0010, 32'h0);
    step();
    drive_core(1'b0, 1'b0, 16'h0, 32'h0);
    repeat (LAT + 1) step();

    // Aux read so that the next tie belongs to the core.
    drive_aux(1'b1, 1'b0, 16'h0003, 32'h0, 1'b0);
    step();
    drive_core(1'b1, 1'b0, 16'h0010, 32'h0);
    drive_aux(1'b1, 1'b1, 16'h0020, 32'h12345678, 1'b0);
    order = '0;
    repeat (4) begin
      step();
      order = {order[2:0], obs_cg};
    end
    chk("rr_order", order, 4'b1010);
    drive_core(1'b0, 1'b0, 16'h0, 32'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    repeat (LAT + 1) step();

    // Reset while a core read is still in flight.
    drive_core(1'b1, 1'b0, 16'h0040, 32'h0);
    step();
    drive_aux(1'b1, 1'b0, 16'h0041, 32'h0, 1'b0);
    do_reset(2);
    drive_core(1'b0, 1'b0, 16'h0, 32'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    repeat (LAT + 2) step();

    // Alternating core/aux reads every cycle.
    for (int i = 0; i < 8; i++) begin
      if (!(core_req && !obs_cg)) drive_core(1'b1, 1'b0, AW'(16'h0010 + i), 32'h0);
      if (!(aux_req && !obs_ag)) drive_aux(1'b1, 1'b0, AW'(16'h0080 + i), 32'h0, 1'b0);
      step();
    end
    drive_core(1'b0, 1'b0, 16'h0, 32'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    repeat (LAT + 1) step();

`ifdef DATA_MEM_ARB_LOCK_EN
    drive_core(1'b1, 1'b0, 16'h0050, 32'h0);
    step();
    drive_aux(1'b1, 1'b1, 16'h0060, 32'h0BAD_F00D, 1'b1);
    order = '0;
    step();
    order = {order[2:0], obs_cg};
    step();
    order = {order[2:0], obs_cg};
    drive_aux(1'b1, 1'b1, 16'h0061, 32'h0BAD_F00E, 1'b0);
    step();
    order = {order[2:0], obs_cg};
    drive_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    step();
    order = {order[2:0], obs_cg};
    chk("lock_core_order", order, 4'b0001);
    drive_core(1'b0, 1'b0, 16'h0, 32'h0);
    repeat (LAT + 1) step();
`endif

    // Random traffic; without an active lock no requester may wait more than one cycle.
    obs_cg = 1'b0; obs_ag = 1'b0;
    cw = 0; aw = 0;
    for (int n = 0; n < 400; n++) begin
`ifdef DATA_MEM_ARB_LOCK_EN
      next_random(1'b0);
`else
      next_random(1'b1);
`endif
      step();
      cw = (core_req && !obs_cg) ? cw + 1 : 0;
      aw = (aux_req && !obs_ag) ? aw + 1 : 0;
      chk("core_wait", cw <= 1, 1'b1);
      chk("aux_wait", aw <= 1, 1'b1);
    end
    drive_core(1'b0, 1'b0, 16'h0, 32'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    repeat (LAT + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
